// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a MIPS-style fetch front end.
//
// Each instruction at pc is decoded combinationally. There is no delay slot,
// and any redirect is loaded on the next advancing clock edge. A candidate
// next PC that is misaligned or outside instruction memory freezes the
// sequencer in FAULT until reset.
//
// Ports:
//   CLK          rising-edge clock
//   reset        asynchronous active-low reset
//   imem_ready   fetch valid; the PC advances only when high
//   opcode       instr[31:26]
//   rt_field     instr[20:16], REGIMM selector
//   func         instr[5:0]
//   imm16        branch offset in words
//   target26     jump target field
//   rs_data      register rs value
//   rt_data      register rt value
//   pc           current instruction address
//   branch_taken current instruction redirects the PC
//   link_we      link-register write request
//   link_addr    link value (pc+4)
//   invpc        sticky invalid-PC fault
//   error        fault cause: bit0 misaligned, bit1 out of range
//   instr_count  retired-instruction count, wraps mod 2^32
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_field,
  input  logic [5:0]  func,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic        branch_taken,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        invpc,
  output logic [1:0]  error,
  output logic [31:0] instr_count
);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // 33 bits so that a byte limit of 2^32 or more still compares correctly.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t             state, state_nxt;
  logic        [31:0] pc_nxt, cnt_nxt;
  logic               invpc_nxt;
  logic        [1:0]  error_nxt;

  logic        [31:0] pc_plus4, br_target, j_target, redirect_pc, next_pc;
  logic signed [31:0] rs_s;
  logic               taken_raw, is_link, run, advance;
  logic        [1:0]  fault_bits;

  // Word offset scaled to bytes, sign-extended to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign rs_s      = signed'(rs_data);
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + branch_offset(imm16);
  assign j_target  = {pc_plus4[31:28], target26, 2'b00};

  // Instruction decode: taken flag, link flag and redirect address.
  always_comb begin
    taken_raw   = 1'b0;
    is_link     = 1'b0;
    redirect_pc = br_target;
    case (opcode)
      OP_SPECIAL: begin
        if (func == FN_JR) begin
          taken_raw   = 1'b1;
          redirect_pc = rs_data;
        end else if (func == FN_JALR) begin
          taken_raw   = 1'b1;
          is_link     = 1'b1;
          redirect_pc = rs_data;
        end
      end
      OP_REGIMM: begin
        case (rt_field)
          5'b00000: taken_raw = (rs_s < 0);
          5'b00001: taken_raw = (rs_s >= 0);
          5'b10000: begin
            taken_raw = (rs_s < 0);
            is_link   = 1'b1;
          end
          5'b10001: begin
            taken_raw = (rs_s >= 0);
            is_link   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J: begin
        taken_raw   = 1'b1;
        redirect_pc = j_target;
      end
      OP_JAL: begin
        taken_raw   = 1'b1;
        is_link     = 1'b1;
        redirect_pc = j_target;
      end
      OP_BEQ:  taken_raw = (rs_data == rt_data);
      OP_BNE:  taken_raw = (rs_data != rt_data);
      OP_BLEZ: taken_raw = (rs_s <= 0);
      OP_BGTZ: taken_raw = (rs_s > 0);
      default: ;
    endcase
  end

  assign next_pc    = taken_raw ? redirect_pc : pc_plus4;
  assign fault_bits = {({1'b0, next_pc} >= PC_LIMIT), (next_pc[1:0] != 2'b00)};

  assign run          = (state == S_RUN);
  assign advance      = run && imem_ready;
  assign branch_taken = run && taken_raw;
  assign link_we      = advance && is_link;
  assign link_addr    = pc_plus4;

  // Next-state logic: commit on a clean advance, freeze on a faulting one.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = instr_count;
    invpc_nxt = invpc;
    error_nxt = error;
    if (advance) begin
      if (fault_bits != 2'b00) begin
        state_nxt = S_FAULT;
        invpc_nxt = 1'b1;
        error_nxt = fault_bits;
      end else begin
        pc_nxt  = next_pc;
        cnt_nxt = instr_count + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      instr_count <= 32'd0;
      invpc       <= 1'b0;
      error       <= 2'b00;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_count <= cnt_nxt;
      invpc       <= invpc_nxt;
      error       <= error_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized run compared against an instruction-level reference model.
module tb_pc_sequencer;

  logic        CLK;
  logic        reset;
  logic        imem_ready;
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic        branch_taken;
  logic        link_we;
  logic [31:0] link_addr;
  logic        invpc;
  logic [1:0]  error;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_fault;
  logic [1:0]  m_err;

  pc_sequencer dut (
    .CLK         (CLK),
    .reset       (reset),
    .imem_ready  (imem_ready),
    .opcode      (opcode),
    .rt_field    (rt_field),
    .func        (func),
    .imm16       (imm16),
    .target26    (target26),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .pc          (pc),
    .branch_taken(branch_taken),
    .link_we     (link_we),
    .link_addr   (link_addr),
    .invpc       (invpc),
    .error       (error),
    .instr_count (instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_instr(input logic [5:0] op, input logic [4:0] rtf, input logic [5:0] fn,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] rs, input logic [31:0] rt);
    opcode = op; rt_field = rtf; func = fn; imm16 = imm; target26 = tgt;
    rs_data = rs; rt_data = rt;
  endtask

  task automatic edge_wait();
    @(posedge CLK);
    #1;
  endtask

  // Architectural meaning of the instruction at address cur.
  function automatic void predict(input logic [31:0] cur, output bit tk, output bit lk,
                                  output logic [31:0] nxt);
    int          rs  = rs_data;
    int          off = int'($signed(imm16)) * 4;
    logic [31:0] seq = cur + 32'd4;
    logic [31:0] dst;
    logic [31:0] jt  = (seq & 32'hF000_0000) | ({6'd0, target26} * 32'd4);
    tk  = 0;
    lk  = 0;
    dst = seq + off;
    if (opcode == 6'd0 && func == 6'd8) begin tk = 1; dst = rs_data; end
    else if (opcode == 6'd0 && func == 6'd9) begin tk = 1; lk = 1; dst = rs_data; end
    else if (opcode == 6'd1) begin
      if (rt_field == 5'd0)  tk = (rs < 0);
      if (rt_field == 5'd1)  tk = (rs >= 0);
      if (rt_field == 5'd16) begin tk = (rs < 0);  lk = 1; end
      if (rt_field == 5'd17) begin tk = (rs >= 0); lk = 1; end
    end
    else if (opcode == 6'd2) begin tk = 1; dst = jt; end
    else if (opcode == 6'd3) begin tk = 1; lk = 1; dst = jt; end
    else if (opcode == 6'd4) tk = (rs_data == rt_data);
    else if (opcode == 6'd5) tk = (rs_data != rt_data);
    else if (opcode == 6'd6) tk = (rs <= 0);
    else if (opcode == 6'd7) tk = (rs > 0);
    nxt = tk ? dst : seq;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_cnt = 32'd0; m_fault = 0; m_err = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_ready = 1'b1;
    set_instr(6'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    edge_wait();
    edge_wait();
    checks++;
    if (pc !== 32'd0 || instr_count !== 32'd0 || invpc !== 1'b0 || error !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: pc=%h cnt=%0d invpc=%b err=%b, want 0/0/0/00",
               pc, instr_count, invpc, error);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 2; i++) begin
      edge_wait();
      checks++;
      if (pc !== 32'(4 * i) || instr_count !== 32'(i)) begin
        errors++;
        $display("FAIL seq_step%0d: pc=%h cnt=%0d, want %h/%0d", i, pc, instr_count, 4 * i, i);
      end
    end
  endtask

  task automatic test_bgez();
    set_instr(6'd1, 5'd1, 6'd0, 16'hFFFE, 26'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (branch_taken !== 1'b1 || link_we !== 1'b0) begin
      errors++;
      $display("FAIL bgez_taken_flags: bt=%b lw=%b, want 1/0", branch_taken, link_we);
    end
    edge_wait();
    checks++;
    if (pc !== 32'h4 || instr_count !== 32'd3) begin
      errors++;
      $display("FAIL bgez_taken_pc: pc=%h cnt=%0d, want 4/3", pc, instr_count);
    end
    set_instr(6'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    edge_wait();
    set_instr(6'd1, 5'd1, 6'd0, 16'hFFFE, 26'd0, 32'h8000_0000, 32'd0);
    #1;
    checks++;
    if (pc !== 32'h8 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL bgez_not_taken_flag: pc=%h bt=%b, want 8/0", pc, branch_taken);
    end
    edge_wait();
    checks++;
    if (pc !== 32'hC || instr_count !== 32'd5) begin
      errors++;
      $display("FAIL bgez_not_taken_pc: pc=%h cnt=%0d, want C/5", pc, instr_count);
    end
  endtask

  task automatic test_bgezal();
    set_instr(6'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    edge_wait();
    set_instr(6'd1, 5'd17, 6'd0, 16'h0040, 26'd0, 32'hFFFF_FFFF, 32'd0);
    #1;
    checks++;
    if (link_we !== 1'b1 || link_addr !== 32'h14 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL bgezal_link: lw=%b la=%h bt=%b, want 1/14/0", link_we, link_addr, branch_taken);
    end
    edge_wait();
    checks++;
    if (pc !== 32'h14 || instr_count !== 32'd7) begin
      errors++;
      $display("FAIL bgezal_pc: pc=%h cnt=%0d, want 14/7", pc, instr_count);
    end
  endtask

  task automatic test_fault_misaligned();
    set_instr(6'd0, 5'd0, 6'd8, 16'd0, 26'd0, 32'h6, 32'd0);
    #1;
    checks++;
    if (branch_taken !== 1'b1) begin
      errors++;
      $display("FAIL jr_taken: bt=%b, want 1", branch_taken);
    end
    edge_wait();
    checks++;
    if (invpc !== 1'b1 || error !== 2'b01 || pc !== 32'h14 || instr_count !== 32'd7) begin
      errors++;
      $display("FAIL jr_fault: invpc=%b err=%b pc=%h cnt=%0d, want 1/01/14/7",
               invpc, error, pc, instr_count);
    end
    // A valid JALR while faulted must neither redirect nor link.
    set_instr(6'd0, 5'd0, 6'd9, 16'd0, 26'd0, 32'h8, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (branch_taken !== 1'b0 || link_we !== 1'b0) begin
        errors++;
        $display("FAIL fault_outputs%0d: bt=%b lw=%b, want 0/0", i, branch_taken, link_we);
      end
      edge_wait();
      checks++;
      if (invpc !== 1'b1 || error !== 2'b01 || pc !== 32'h14 || instr_count !== 32'd7) begin
        errors++;
        $display("FAIL fault_hold%0d: invpc=%b err=%b pc=%h cnt=%0d, want 1/01/14/7",
                 i, invpc, error, pc, instr_count);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0 || invpc !== 1'b0 || error !== 2'b00 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL fault_reset: pc=%h invpc=%b err=%b cnt=%0d, want 0/0/00/0",
               pc, invpc, error, instr_count);
    end
    edge_wait();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_stall_range();
    imem_ready = 1'b0;
    set_instr(6'd3, 5'd0, 6'd0, 16'd0, 26'h400, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (link_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_link%0d: lw=%b, want 0", i, link_we);
      end
      edge_wait();
      checks++;
      if (pc !== 32'd0 || instr_count !== 32'd0 || invpc !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%h cnt=%0d invpc=%b, want 0/0/0",
                 i, pc, instr_count, invpc);
      end
    end
    imem_ready = 1'b1;
    set_instr(6'd2, 5'd0, 6'd0, 16'd0, 26'h400, 32'd0, 32'd0);
    edge_wait();
    checks++;
    if (invpc !== 1'b1 || error !== 2'b10 || pc !== 32'd0 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL j_range: invpc=%b err=%b pc=%h cnt=%0d, want 1/10/0/0",
               invpc, error, pc, instr_count);
    end
    #2;
    reset = 1'b0;
    edge_wait();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic random_instr();
    int sel = $urandom_range(0, 9);
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rtf;
    logic [25:0] tgt;
    case ($urandom_range(0, 6))
      0: rs = 32'd0;
      1: rs = 32'd1;
      2: rs = 32'hFFFF_FFFF;
      3: rs = 32'h8000_0000;
      4: rs = 32'($urandom_range(0, 1023)) * 32'd4;
      5: rs = 32'($urandom_range(0, 1023)) * 32'd4 + 32'd2;
      default: rs = $urandom;
    endcase
    rt  = ($urandom_range(0, 1) == 0) ? rs : $urandom;
    case ($urandom_range(0, 4))
      0: rtf = 5'd0;
      1: rtf = 5'd1;
      2: rtf = 5'd16;
      3: rtf = 5'd17;
      default: rtf = 5'($urandom);
    endcase
    tgt = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, 1023));
    set_instr(6'd0, rtf, 6'($urandom), 16'($urandom_range(0, 16) - 8), tgt, rs, rt);
    case (sel)
      0: func = 6'd0;
      1: opcode = 6'd4;
      2: opcode = 6'd5;
      3: opcode = 6'd6;
      4: opcode = 6'd7;
      5: opcode = 6'd1;
      6: opcode = 6'd2;
      7: opcode = 6'd3;
      8: func = ($urandom_range(0, 1) == 0) ? 6'd8 : 6'd9;
      default: opcode = 6'($urandom_range(8, 63));
    endcase
  endtask

  task automatic test_random();
    bit          tk, lk;
    logic [31:0] nxt;
    logic [1:0]  bad;
    for (int n = 0; n < 400; n++) begin
      random_instr();
      imem_ready = ($urandom_range(0, 3) != 0);
      #1;
      predict(m_pc, tk, lk, nxt);
      checks++;
      if (branch_taken !== (tk && !m_fault) || link_we !== (lk && !m_fault && imem_ready) ||
          link_addr !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL rnd_comb%0d: bt=%b lw=%b la=%h, want %b/%b/%h", n, branch_taken,
                 link_we, link_addr, tk && !m_fault, lk && !m_fault && imem_ready, m_pc + 32'd4);
      end
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
        // Reset arriving between edges wins over whatever was in flight.
        reset = 1'b0;
        #1;
        model_reset();
        edge_wait();
        reset = 1'b1;
      end else begin
        edge_wait();
        if (!m_fault && imem_ready) begin
          bad = {nxt >= 32'd4096, nxt % 4 != 0};
          if (bad != 2'b00) begin
            m_fault = 1;
            m_err   = bad;
          end else begin
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
          end
        end
      end
      checks++;
      if (pc !== m_pc || instr_count !== m_cnt || invpc !== m_fault || error !== m_err) begin
        errors++;
        $display("FAIL rnd_state%0d: pc=%h cnt=%0d invpc=%b err=%b, want %h/%0d/%b/%b", n,
                 pc, instr_count, invpc, error, m_pc, m_cnt, m_fault, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bgez();
    test_bgezal();
    test_fault_misaligned();
    test_stall_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, instruction memory depth in 32-bit words.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_ready  input  1  fetch valid; the PC advances only when high.
REQ-006 SHALL have port opcode  input  6  instruction [31:26] of the instruction at pc.
REQ-007 SHALL have port rt_field  input  5  instruction [20:16] (REGIMM selector).
REQ-008 SHALL have port func  input  6  instruction [5:0].
REQ-009 SHALL have port imm16  input  16  branch offset, in words.
REQ-010 SHALL have port target26  input  26  jump target field.
REQ-011 SHALL have port rs_data  input  32  register rs value.
REQ-012 SHALL have port rt_data  input  32  register rt value.
REQ-013 SHALL have port pc  output  32  current instruction address.
REQ-014 SHALL have port branch_taken  output  1  the current instruction redirects the PC.
REQ-015 SHALL have port link_we  output  1  link-register write request.
REQ-016 SHALL have port link_addr  output  32  link value, equal to pc+4.
REQ-017 SHALL have port invpc  output  1  sticky invalid-PC fault.
REQ-018 SHALL have port error  output  2  fault cause.
REQ-019 SHALL have port instr_count  output  32  count of retired instructions.

Function
REQ-020 SHALL decode the instruction combinationally from pc; there is no delay slot, and the redirect takes effect on the next advancing edge.
REQ-021 SHALL use two states: RUN and FAULT.
REQ-022 SHALL, in RUN with imem_ready=1, load next_pc into pc on the rising edge and increment instr_count (mod 2^32, wraps silently).
REQ-023 SHALL, when imem_ready=0, hold pc, instr_count and state; link_we SHALL be 0.
REQ-024 SHALL compute the branch target as pc+4+(sign-extended imm16<<2), 32-bit modulo arithmetic.
REQ-025 SHALL compute the jump target as {pc_plus4[31:28], target26, 2'b00}; the JR/JALR target SHALL be rs_data.
REQ-026 SHALL evaluate branch conditions as signed compares on rs_data:
- BEQ 000100: rs==rt
- BNE 000101: rs!=rt
- BLEZ 000110: rs<=0
- BGTZ 000111: rs>0
- REGIMM 000001 with rt_field 00000 BLTZ: rs<0
- REGIMM rt_field 00001 BGEZ: rs>=0
- REGIMM rt_field 10000 BLTZAL: rs<0
- REGIMM rt_field 10001 BGEZAL: rs>=0
REQ-027 SHALL treat J 000010, JAL 000011, and SPECIAL 000000 with func 001000 (JR) or 001001 (JALR) as always taken.
REQ-028 SHALL set next_pc to pc+4 for any other encoding, including unknown REGIMM rt_field values; branch_taken SHALL be 0.
REQ-029 SHALL assert link_we for JAL, JALR, BLTZAL and BGEZAL regardless of condition, only in RUN with imem_ready=1.
REQ-030 SHALL treat a candidate next_pc as invalid if next_pc[1:0]!=0 (error bit 0) or next_pc>=4*MEM_WORDS (error bit 1).
- Both error bits SHALL be set if both conditions hold.
REQ-031 SHALL, on an advancing edge with an invalid next_pc:
- hold pc
- not increment instr_count
- enter FAULT
- set invpc=1
- latch error.
REQ-032 SHALL, in FAULT, hold pc, instr_count, invpc and error constant; link_we and branch_taken SHALL be 0.
- The only exit from FAULT is reset.
REQ-033 SHALL evaluate a fault only on an advancing edge; an invalid next_pc while imem_ready=0 SHALL have no effect.

Reset
REQ-034 SHALL, on reset low, immediately set pc=RESET_PC, state=RUN, invpc=0, error=2'b00, instr_count=0, independent of CLK.
REQ-035 SHALL hold all state while reset is low; the first advance occurs on the first rising edge with reset high and imem_ready=1.
REQ-036 SHALL let a reset asserted mid-operation or in FAULT override any in-flight update on that edge.

Verification
REQ-037 SHALL cover sequential flow: reset, nop (all zero), imem_ready=1 for 2 edges -> pc=0x8, instr_count=2.
REQ-038 SHALL cover BGEZ taken: pc=0x8, rs_data=0, imm16=0xFFFE -> branch_taken=1; next pc=0x4.
REQ-039 SHALL cover BGEZ not taken: pc=0x8, rs_data=0x80000000 -> branch_taken=0; next pc=0xC.
REQ-040 SHALL cover BGEZAL not taken: pc=0x10, rs_data=0xFFFFFFFF -> link_we=1, link_addr=0x14; next pc=0x14.
REQ-041 SHALL cover misaligned JR: rs_data=0x6 -> invpc=1, error=01, pc unchanged.
- The fault SHALL persist over 5 further edges.
- reset low SHALL then give pc=0, invpc=0.
REQ-042 SHALL cover stall and out-of-range jump:
- imem_ready=0 for 3 edges -> pc and instr_count constant.
- J with target26=0x400 (0x1000 >= 4*1024) -> invpc=1, error=10.
